// File: rtl/puf_verifier.sv
// rtl/puf_verifier.sv - ring-oscillator PUF challenge sequencer with enroll/verify Hamming check
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous reset, active-high
//   start     begin a run (sampled only in IDLE)
//   mode      0 = enroll, 1 = verify (latched with start)
//   puf_resp  PUF counter response, asynchronous to clk
//   puf_chal  challenge select to the PUF (zero-extended challenge index)
//   puf_en    oscillator enable (measurement window)
//   puf_clr   PUF counter clear, active-high
//   busy      high from start acceptance until done
//   done      single-cycle pulse at run end
//   pass      verify result, valid from done until next accepted start
//   hd_total  accumulated Hamming distance of the last run
//   enrolled  a complete enrollment is stored
module puf_verifier #(
    parameter int NCHAL  = 8,
    parameter int WINDOW = 64,
    parameter int SETTLE = 2,
    parameter int RW     = 8,
    parameter int HD_MAX = 6,
    localparam int HW    = $clog2(NCHAL * RW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [RW-1:0] puf_resp,
    output logic [4:0]    puf_chal,
    output logic          puf_en,
    output logic          puf_clr,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [HW-1:0] hd_total,
    output logic          enrolled
);

    localparam int IW = (NCHAL > 1) ? $clog2(NCHAL) : 1;
    localparam int CMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_CAPTURE,
        ST_FINISH
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          mode_r;
    logic [RW-1:0] sync1;
    logic [RW-1:0] sync2;
    logic [RW-1:0] mem [NCHAL];
    logic [HW-1:0] hd_next;

    function automatic logic [HW-1:0] popcount(input logic [RW-1:0] v);
        logic [HW-1:0] n;
        n = '0;
        for (int b = 0; b < RW; b++) begin
            n = n + HW'(v[b]);
        end
        return n;
    endfunction

    assign puf_chal = 5'(idx);
    assign hd_next  = hd_total + popcount(sync2 ^ mem[idx]);

    // Reference store is deliberately not reset; enrolled says whether it is valid.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE && !mode_r) begin
            mem[idx] <= sync2;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            mode_r   <= 1'b0;
            sync1    <= '0;
            sync2    <= '0;
            puf_en   <= 1'b0;
            puf_clr  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            hd_total <= '0;
            enrolled <= 1'b0;
        end else begin
            sync1 <= puf_resp;
            sync2 <= sync1;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    puf_clr <= 1'b0;
                    if (start) begin
                        mode_r   <= mode;
                        idx      <= '0;
                        hd_total <= '0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        // A new enrollment invalidates the old one up front so an
                        // aborted run never leaves partial data marked valid.
                        if (!mode) begin
                            enrolled <= 1'b0;
                        end
                        if (!mode || enrolled) begin
                            puf_clr <= 1'b1;
                            state   <= ST_CLEAR;
                        end else begin
                            hd_total <= '1;
                            done     <= 1'b1;
                            state    <= ST_FINISH;
                        end
                    end
                end
                ST_CLEAR: begin
                    puf_clr <= 1'b0;
                    puf_en  <= 1'b1;
                    cnt     <= CW'(WINDOW - 1);
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt == '0) begin
                        puf_en <= 1'b0;
                        cnt    <= CW'(SETTLE - 1);
                        state  <= ST_SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Counter is frozen; this gap also flushes the synchronizer.
                    if (cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (mode_r) begin
                        hd_total <= hd_next;
                    end
                    if (idx == IW'(NCHAL - 1)) begin
                        // Result registers change on the same edge that raises done.
                        done  <= 1'b1;
                        state <= ST_FINISH;
                        if (mode_r) begin
                            pass <= (int'(hd_next) <= HD_MAX);
                        end else begin
                            enrolled <= 1'b1;
                            pass     <= 1'b0;
                        end
                    end else begin
                        idx     <= idx + 1'b1;
                        puf_clr <= 1'b1;
                        state   <= ST_CLEAR;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_verifier.sv
// tb/tb_puf_verifier.sv - directed self-checking bench for puf_verifier
module tb_puf_verifier;

    localparam int NCHAL = 8;
    localparam int T = 64 + 2 + 2;
    // Edges after the start-sampling edge until done is seen high (done in cycle k+1+NCHAL*T).
    localparam int LAT_FULL = NCHAL * T;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] puf_resp;
    logic [4:0] puf_chal;
    logic       puf_en;
    logic       puf_clr;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] hd_total;
    logic       enrolled;

    logic [7:0] resp_tab [32];

    int tests = 0;
    int fails = 0;

    int en_cycles = 0;
    int en_rises = 0;
    int en_len = 0;
    int last_len = 0;
    int clr_cycles = 0;
    int done_cnt = 0;
    bit en_prev = 1'b0;

    puf_verifier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .puf_resp (puf_resp),
        .puf_chal (puf_chal),
        .puf_en   (puf_en),
        .puf_clr  (puf_clr),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .hd_total (hd_total),
        .enrolled (enrolled)
    );

    assign puf_resp = resp_tab[puf_chal];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (puf_en) begin
            en_cycles++;
            en_len++;
            if (!en_prev) en_rises++;
        end else begin
            if (en_prev) last_len = en_len;
            en_len = 0;
        end
        en_prev = puf_en;
        if (puf_clr) clr_cycles++;
        if (done) done_cnt++;
    end

    task automatic set_base();
        for (int i = 0; i < 32; i++) resp_tab[i] = 8'(8'hA0 + i);
    endtask

    task automatic run_op(input logic m, output int lat);
        @(negedge clk);
        mode = m;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mode = ~m;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        set_base();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (puf_clr !== 1'b1) begin fails++; $display("FAIL reset_clr: got %0h expected 1", puf_clr); end
        tests++; if (puf_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %0h expected 0", puf_en); end
        tests++; if (puf_chal !== 5'd0) begin fails++; $display("FAIL reset_chal: got %0h expected 0", puf_chal); end
        tests++; if ({busy, done, pass, enrolled} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, enrolled}); end
        tests++; if (hd_total !== 7'd0) begin fails++; $display("FAIL reset_hd: got %0h expected 0", hd_total); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (puf_clr !== 1'b0) begin fails++; $display("FAIL idle_clr: got %0h expected 0", puf_clr); end
    endtask

    task automatic test_unenrolled_verify();
        int lat;
        int s_rise;
        s_rise = en_rises;
        run_op(1'b1, lat);
        tests++; if (lat !== 0) begin fails++; $display("FAIL unenr_latency: got %0d expected 0", lat); end
        tests++; if (hd_total !== 7'h7F) begin fails++; $display("FAIL unenr_hd: got %0h expected 7f", hd_total); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL unenr_pass: got %0h expected 0", pass); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL unenr_busy_at_done: got %0h expected 1", busy); end
        @(negedge clk);
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL unenr_after: got %b expected 00", {busy, done}); end
        tests++; if (en_rises - s_rise !== 0) begin fails++; $display("FAIL unenr_en_activity: got %0d expected 0", en_rises - s_rise); end
    endtask

    task automatic test_enroll();
        int lat;
        int s_en;
        int s_rise;
        int s_clr;
        set_base();
        s_en = en_cycles;
        s_rise = en_rises;
        s_clr = clr_cycles;
        run_op(1'b0, lat);
        tests++; if (lat !== LAT_FULL) begin fails++; $display("FAIL enroll_latency: got %0d expected %0d", lat, LAT_FULL); end
        tests++; if (enrolled !== 1'b1) begin fails++; $display("FAIL enroll_flag: got %0h expected 1", enrolled); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL enroll_pass: got %0h expected 0", pass); end
        @(negedge clk);
        tests++; if (en_cycles - s_en !== 512) begin fails++; $display("FAIL enroll_en_cycles: got %0d expected 512", en_cycles - s_en); end
        tests++; if (en_rises - s_rise !== 8) begin fails++; $display("FAIL enroll_en_pulses: got %0d expected 8", en_rises - s_rise); end
        tests++; if (last_len !== 64) begin fails++; $display("FAIL enroll_en_width: got %0d expected 64", last_len); end
        tests++; if (clr_cycles - s_clr !== 8) begin fails++; $display("FAIL enroll_clr_pulses: got %0d expected 8", clr_cycles - s_clr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL enroll_busy_after: got %0h expected 0", busy); end
    endtask

    task automatic test_verify(input string name, input logic [7:0] m0, input int c0,
                               input logic [7:0] m1, input int c1,
                               input logic [6:0] exp_hd, input logic exp_pass);
        int lat;
        set_base();
        resp_tab[c0] = resp_tab[c0] ^ m0;
        resp_tab[c1] = resp_tab[c1] ^ m1;
        run_op(1'b1, lat);
        tests++; if (lat !== LAT_FULL) begin fails++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT_FULL); end
        tests++; if (hd_total !== exp_hd) begin fails++; $display("FAIL %s_hd: got %0d expected %0d", name, hd_total, exp_hd); end
        tests++; if (pass !== exp_pass) begin fails++; $display("FAIL %s_pass: got %0h expected %0h", name, pass, exp_pass); end
        repeat (3) @(negedge clk);
        tests++; if ({hd_total, pass} !== {exp_hd, exp_pass}) begin fails++; $display("FAIL %s_hold: got %0h expected %0h", name, {hd_total, pass}, {exp_hd, exp_pass}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int s_done;
        int s_rise;
        set_base();
        s_done = done_cnt;
        s_rise = en_rises;
        @(negedge clk);
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            mode = 1'b1;
            start = (lat == 100 || lat == 300);
        end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tests++; if (lat !== LAT_FULL) begin fails++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT_FULL); end
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL b2b_after_finish: got %b expected 00", {busy, done}); end
        repeat (5) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_no_restart: got %0h expected 0", busy); end
        tests++; if (done_cnt - s_done !== 1) begin fails++; $display("FAIL b2b_done_pulses: got %0d expected 1", done_cnt - s_done); end
        tests++; if (en_rises - s_rise !== 8) begin fails++; $display("FAIL b2b_en_pulses: got %0d expected 8", en_rises - s_rise); end
        tests++; if (enrolled !== 1'b1) begin fails++; $display("FAIL b2b_enrolled: got %0h expected 1", enrolled); end
    endtask

    task automatic test_all_ones();
        int lat;
        set_base();
        resp_tab[2] = 8'h00;
        run_op(1'b0, lat);
        tests++; if (lat !== LAT_FULL) begin fails++; $display("FAIL ones_enroll_latency: got %0d expected %0d", lat, LAT_FULL); end
        set_base();
        resp_tab[2] = 8'hFF;
        run_op(1'b1, lat);
        tests++; if (hd_total !== 7'd8) begin fails++; $display("FAIL ones_hd: got %0d expected 8", hd_total); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL ones_pass: got %0h expected 0", pass); end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int lat;
        set_base();
        @(negedge clk);
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3 * T + 10) @(posedge clk);
        @(negedge clk);
        tests++; if ({puf_chal, puf_en} !== {5'd3, 1'b1}) begin fails++; $display("FAIL midrun_pos: got %0h expected %0h", {puf_chal, puf_en}, {5'd3, 1'b1}); end
        #2;
        rst_n = 1'b1;
        #1;
        tests++; if ({puf_en, puf_clr, puf_chal} !== {1'b0, 1'b1, 5'd0}) begin fails++; $display("FAIL midrun_pins: got %0h expected %0h", {puf_en, puf_clr, puf_chal}, {1'b0, 1'b1, 5'd0}); end
        tests++; if ({busy, done, pass, enrolled} !== 4'b0) begin fails++; $display("FAIL midrun_flags: got %b expected 0000", {busy, done, pass, enrolled}); end
        tests++; if (hd_total !== 7'd0) begin fails++; $display("FAIL midrun_hd: got %0h expected 0", hd_total); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        run_op(1'b1, lat);
        tests++; if (lat !== 0) begin fails++; $display("FAIL midrun_verify_latency: got %0d expected 0", lat); end
        tests++; if ({hd_total, pass} !== {7'h7F, 1'b0}) begin fails++; $display("FAIL midrun_verify_result: got %0h expected %0h", {hd_total, pass}, {7'h7F, 1'b0}); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unenrolled_verify();
        test_enroll();
        test_verify("match", 8'h00, 0, 8'h00, 1, 7'd0, 1'b1);
        test_verify("hd6", 8'h07, 1, 8'h38, 4, 7'd6, 1'b1);
        test_verify("hd7", 8'h01, 0, 8'hFC, 7, 7'd7, 1'b0);
        test_back_to_back();
        test_verify("b2b_match", 8'h00, 3, 8'h00, 5, 7'd0, 1'b1);
        test_all_ones();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/puf_verifier.md
# puf_verifier

Challenge sequencer and response checker that drives the ring-oscillator PUF from its challenge side. It enrolls a reference response set by issuing every challenge in turn and storing the captured counts, then in verify mode re-issues the same challenges. Each fresh response is compared against the enrolled value by Hamming distance, and a pass/fail result is reported against a tolerance. It sits between system control and the PUF's challenge, enable, clear and response pins.

## Interface
- NCHAL, 8: number of challenges per run; 1..32. Challenge index i is driven zero-extended on puf_chal.
- WINDOW, 64: clk cycles puf_en is held high per challenge (measurement window).
- SETTLE, 2: clk cycles after puf_en falls before the response is captured.
- RW, 8: response width.
- HD_MAX, 6: maximum total mismatched bits over all challenges for pass.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- mode  input  1  0 = enroll, 1 = verify; latched with start.
- puf_resp  input  RW  PUF counter response; asynchronous to clk, passed through a 2-flop synchronizer.
- puf_chal  output  5  challenge select to PUF.
- puf_en  output  1  oscillator enable.
- puf_clr  output  1  PUF counter clear; active-high.
- busy  output  1  high from start acceptance until done.
- done  output  1  single-cycle pulse at run end.
- pass  output  1  verify result; valid from done until next accepted start.
- hd_total  output  clog2(NCHAL*RW+1)  accumulated Hamming distance (7 bits at defaults).
- enrolled  output  1  a complete enrollment has been stored.

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, CAPTURE, FINISH.
- IDLE: start=1 latches mode and clears idx, hd_total and pass.
  - Enroll, or verify with enrolled=1 -> CLEAR.
  - Verify with enrolled=0 -> FINISH with hd_total forced to all ones, pass=0, and no PUF activity.
- CLEAR: 1 cycle. puf_clr=1, puf_en=0. -> RUN.
- RUN: WINDOW cycles. puf_en=1, puf_clr=0. -> SETTLE.
- SETTLE: SETTLE cycles. puf_en=0. The counter is frozen, and the synchronizer flushes. -> CAPTURE.
- CAPTURE: 1 cycle. r = synchronized puf_resp.
  - Enroll: mem[idx] <= r.
  - Verify: hd_total <= hd_total + popcount(r ^ mem[idx]). No saturation is needed; the width covers the maximum.
  - If idx == NCHAL-1 -> FINISH; otherwise idx+1 -> CLEAR.
- FINISH: 1 cycle. done=1.
  - Enroll: enrolled <= 1 and pass <= 0.
  - Verify: pass <= (hd_total <= HD_MAX).
  - -> IDLE.
- puf_chal = idx in every state, including IDLE (idx is 0 there).
- Storage: NCHAL x RW registers. Contents are not reset; enrolled gates their use.
- start outside IDLE is ignored. mode changes mid-run have no effect.
- A new enroll run clears enrolled at acceptance, so an aborted enrollment never leaves stale data marked valid.

## Timing
- Reset values: state=IDLE, idx=0, puf_chal=0, puf_en=0, puf_clr=1 (the PUF is held cleared during reset), busy=0, done=0, pass=0, hd_total=0, enrolled=0, synchronizer=0.
- Reset asserted mid-run aborts immediately to the reset values. enrolled=0, so any partial enrollment is discarded.
- After reset release, puf_clr=0 in IDLE.
- Per-challenge cost: T = WINDOW + SETTLE + 2 cycles (68 at defaults).
- Latency:
  - start sampled at edge k: busy=1 and CLEAR in cycle k+1.
  - done is high in cycle k+1+NCHAL*T (545 at defaults).
  - busy falls together with done's deassertion.
  - Verify with enrolled=0: done in cycle k+1.
- pass and hd_total update on the edge that raises done and hold until the next accepted start.
- A start coincident with done (the FSM in FINISH) is ignored; start is accepted from the following IDLE cycle.

## Test plan
- Enroll, then verify against a bench PUF model that returns 8'hA0+i for challenge i:
  - Enroll gives done at cycle 545 and enrolled=1.
  - Verify gives hd_total=0 and pass=1.
  - puf_en width is 64 cycles, and puf_clr pulses 8 times.
- Verify with model responses flipping 6 bits total across challenges -> hd_total=6, pass=1. Flipping 7 bits -> hd_total=7, pass=0.
- Verify after reset with no enrollment -> done in cycle k+1, pass=0, hd_total=7'h7F, puf_en never asserted.
- Assert rst_n during RUN of challenge 3 of an enroll -> all outputs take their reset values and enrolled=0. A subsequent verify fails immediately.
- Pulse start while busy, and again in the FINISH cycle -> no restart, done pulses exactly once, and latency is unchanged.
- All-ones vs all-zeros response model for one challenge -> hd_total=8 (RW bits), pass=0.
